// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared types and constants for the register file writeback queue
package regfile_wb_pkg;

    localparam logic [4:0] XZR_IDX   = 5'd31;
    localparam int         DEPTH_DEF = 4;
    localparam int         AW_DEF    = 5;
    localparam int         DW_DEF    = 64;

    typedef struct packed {
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_queue_match.sv
// rtl/regfile_wb_queue_match.sv - youngest pending-entry lookup for one read port
module wb_match
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PW    = $clog2(DEPTH)
) (
    input  wb_entry_t           entries [DEPTH],
    input  logic [DEPTH-1:0]    valid,
    input  logic [PW-1:0]       head,
    input  logic [PW:0]         count,
    input  logic [AW_DEF-1:0]   ra,
    output logic                hit,
    output logic [DW_DEF-1:0]   data
);

    logic [PW-1:0] idx;

    // Walk from oldest to youngest so the last match seen wins.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((PW+1)'(i) < count && valid[idx] &&
                entries[idx].addr == ra && ra != XZR_IDX) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order writeback buffer driving the register file write port
module regfile_wb_queue
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [AW-1:0]             in_addr,
    input  logic [DW-1:0]             in_data,
    input  logic                      wb_stall,
    output logic                      we3,
    output logic [AW-1:0]             wa3,
    output logic [DW-1:0]             wd3,
    input  logic [AW-1:0]             ra1,
    input  logic [AW-1:0]             ra2,
    output logic                      hit1,
    output logic                      hit2,
    output logic [DW-1:0]             fd1,
    output logic [DW-1:0]             fd2,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [DEPTH-1:0] valid;
    logic             push;
    logic             store;
    logic             pop;

    assign in_ready = count < CW'(DEPTH);
    assign empty    = count == '0;
    assign push     = in_valid && in_ready;
    // XZR writes complete the handshake but never occupy a slot.
    assign store    = push && (in_addr != XZR_IDX);
    assign pop      = !empty && !wb_stall;

    assign we3 = pop;
    assign wa3 = pop ? mem[head].addr : '0;
    assign wd3 = pop ? mem[head].data : '0;

    always_comb begin
        valid = '0;
        for (int j = 0; j < DEPTH; j++) begin
            valid[j] = CW'(PW'(j) - head) < count;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store) tail <= tail + 1'b1;
            if (pop)   head <= head + 1'b1;
            count <= count + CW'(store) - CW'(pop);
        end
    end

    // Payload storage needs no reset; the valid window is defined by head/count.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[tail].addr <= in_addr;
            mem[tail].data <= in_data;
        end
    end

    wb_match #(.DEPTH(DEPTH)) u_match1 (
        .entries (mem),
        .valid   (valid),
        .head    (head),
        .count   (count),
        .ra      (ra1),
        .hit     (hit1),
        .data    (fd1)
    );

    wb_match #(.DEPTH(DEPTH)) u_match2 (
        .entries (mem),
        .valid   (valid),
        .head    (head),
        .count   (count),
        .ra      (ra2),
        .hit     (hit2),
        .data    (fd2)
    );

endmodule
